// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per cycle, LSB first, result valid on a one-cycle DONE pulse.
// Build option: define SERIAL_ADDER_SUB_EN to honour SUB (A - B via ~B and forced carry-in).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             CIN,
  input  logic             SUB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry, carry_next, s_bit, last;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap = SUB ? ~B_IN : B_IN;
  assign c_cap = CIN | SUB;
`else
  logic unused_sub;
  assign unused_sub = SUB;
  assign b_cap      = B_IN;
  assign c_cap      = CIN;
`endif

  // Two half-adder stages form the full-adder bit slice.
  logic h1_s, h1_c, h2_c;
  assign h1_s       = a_sh[0] ^ b_sh[0];
  assign h1_c       = a_sh[0] & b_sh[0];
  assign s_bit      = h1_s ^ carry;
  assign h2_c       = h1_s & carry;
  assign carry_next = h1_c | h2_c;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = s_bit;
    end else begin : g_res_wn
      assign res_next = {s_bit, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = RUN;
      RUN:     if (last)  state_next = FIN;
      FIN:     state_next = START ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == RUN);
    DONE = (state == FIN);
  end

  // Published outputs load only on the final RUN cycle so they hold across a following run.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            a_sh  <= A_IN;
            b_sh  <= b_cap;
            carry <= c_cap;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= res_next;
          carry <= carry_next;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            SUM  <= res_next;
            COUT <= carry_next;
            OVF  <= carry ^ carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 instance plus a WIDTH=1 instance).
module tb_serial_adder;

  logic       clk, rst_n;
  logic       start, cin, sub;
  logic [7:0] a_in, b_in;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start1, cin1, sub1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, cout1, ovf1;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .A_IN(a_in), .B_IN(b_in),
    .CIN(cin), .SUB(sub), .BUSY(busy), .DONE(done), .SUM(sum),
    .COUT(cout), .OVF(ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .A_IN(a1), .B_IN(b1),
    .CIN(cin1), .SUB(sub1), .BUSY(busy1), .DONE(done1), .SUM(sum1),
    .COUT(cout1), .OVF(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed add vectors: {A, B, CIN} -> {SUM, COUT, OVF}
  logic [7:0] va  [4] = '{8'hFF, 8'h7F, 8'h3C, 8'h80};
  logic [7:0] vb  [4] = '{8'h01, 8'h01, 8'h5A, 8'h80};
  logic       vc  [4] = '{1'b0,  1'b0,  1'b1,  1'b0};
  logic [7:0] vs  [4] = '{8'h00, 8'h80, 8'h97, 8'h00};
  logic       vco [4] = '{1'b1,  1'b0,  1'b0,  1'b1};
  logic       vov [4] = '{1'b0,  1'b1,  1'b1,  1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation for one accept edge, then scrambles the inputs.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    a_in = a; b_in = b; cin = c; sub = s; start = 1'b1;
    tick();
    start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c; sub = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1; start1 = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w8: busy=%b done=%b sum=%h cout=%b ovf=%b, all required 0", busy, done, sum, cout, ovf);
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_w1: busy=%b done=%b sum=%b cout=%b ovf=%b, all required 0", busy1, done1, sum1, cout1, ovf1);
    end
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_timing();
    start_op(8'h00, 8'h00, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_busy_c%0d: busy=%b done=%b, required busy=1 done=0", c, busy, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: busy=%b done=%b, required busy=0 done=1", busy, done);
    end
    checks++;
    if ({sum, cout, ovf} !== 10'h000) begin
      errors++;
      $display("FAIL zero_result: sum=%h cout=%b ovf=%b, required 00 0 0", sum, cout, ovf);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: busy=%b done=%b, required 0 0 after one cycle", busy, done);
    end
  endtask

  task automatic test_add();
    int n;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vc[i], 1'b0);
      wait_done(n);
      checks++;
      if (n !== 8) begin
        errors++;
        $display("FAIL add%0d_latency: %0d cycles, required 8", i, n);
      end
      checks++;
      if (sum !== vs[i] || cout !== vco[i] || ovf !== vov[i]) begin
        errors++;
        $display("FAIL add%0d_result: sum=%h cout=%b ovf=%b, required %h %b %b",
                 i, sum, cout, ovf, vs[i], vco[i], vov[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    tick(); tick(); tick();
    a_in = 8'hAA; b_in = 8'h11;
    wait_done(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL b2b_first_latency: %0d cycles after mid-run change, required 5", n);
    end
    checks++;
    if (sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_result: sum=%h cout=%b, required 46 0", sum, cout);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h46) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b sum=%h, required 1 0 46", busy, done, sum);
    end
    wait_done(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL b2b_gap: %0d cycles, required 8 (9 between pulses)", n);
    end
    checks++;
    if (sum !== 8'hBB || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_result: sum=%h cout=%b ovf=%b, required BB 0 0", sum, cout, ovf);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int n;
    bit seen;
    start_op(8'h11, 8'h22, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, all required 0", busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: activity seen=%b after aborted run, required 0", seen);
    end
    start_op(8'h11, 8'h22, 1'b0, 1'b0);
    wait_done(n);
    checks++;
    if (n !== 8 || sum !== 8'h33) begin
      errors++;
      $display("FAIL abort_restart: latency=%0d sum=%h, required 8 33", n, sum);
    end
  endtask

  task automatic test_sub();
    int n;
    logic [7:0] e_sum0, e_sum1;
    logic       e_co0, e_co1;
`ifdef SERIAL_ADDER_SUB_EN
    e_sum0 = 8'hFE; e_co0 = 1'b0; e_sum1 = 8'h02; e_co1 = 1'b1;
`else
    e_sum0 = 8'h0C; e_co0 = 1'b0; e_sum1 = 8'h0C; e_co1 = 1'b0;
`endif
    start_op(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(n);
    checks++;
    if (n !== 8 || sum !== e_sum0 || cout !== e_co0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_5_7: lat=%0d sum=%h cout=%b ovf=%b, required 8 %h %b 0", n, sum, cout, ovf, e_sum0, e_co0);
    end
    start_op(8'h07, 8'h05, 1'b0, 1'b1);
    wait_done(n);
    checks++;
    if (n !== 8 || sum !== e_sum1 || cout !== e_co1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_7_5: lat=%0d sum=%h cout=%b ovf=%b, required 8 %h %b 0", n, sum, cout, ovf, e_sum1, e_co1);
    end
  endtask

  task automatic test_width1();
    logic [0:0] ta [2] = '{1'b1, 1'b0};
    logic [0:0] tb [2] = '{1'b1, 1'b0};
    logic       tc [2] = '{1'b1, 1'b1};
    logic [2:0] te [2] = '{3'b110, 3'b101};  // {SUM, COUT, OVF}
    int n;
    for (int i = 0; i < 2; i++) begin
      a1 = ta[i]; b1 = tb[i]; cin1 = tc[i]; sub1 = 1'b0; start1 = 1'b1;
      tick();
      start1 = 1'b0; a1 = ~ta[i]; b1 = ~tb[i]; cin1 = ~tc[i];
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_%0d_busy: busy=%b done=%b, required 1 0", i, busy1, done1);
      end
      n = -1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (done1 === 1'b1) begin
          n = k;
          break;
        end
      end
      checks++;
      if (n !== 1 || {sum1, cout1, ovf1} !== te[i]) begin
        errors++;
        $display("FAIL w1_%0d_result: lat=%0d sum/cout/ovf=%b, required 1 %b", i, n, {sum1, cout1, ovf1}, te[i]);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    test_reset();
    test_zero_timing();
    test_add();
    test_back_to_back();
    test_reset_abort();
    test_sub();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port START  input  1  request; sampled only when idle or done.
REQ-005 SHALL have port A_IN  input  WIDTH  operand A, captured on accepted START.
REQ-006 SHALL have port B_IN  input  WIDTH  operand B, captured on accepted START.
REQ-007 SHALL have port CIN  input  1  carry-in, captured on accepted START.
REQ-008 SHALL have port SUB  input  1  subtract select, captured on accepted START (see Configuration).
REQ-009 SHALL have port BUSY  output  1  high while computing.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port SUM  output  WIDTH  result.
REQ-012 SHALL have port COUT  output  1  carry out of MSB.
REQ-013 SHALL have port OVF  output  1  two's-complement overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIN; FIN lasts exactly one cycle.
REQ-015 IDLE/FIN with START=1 SHALL capture A_IN, B_IN, CIN, SUB, clear bit counter, go to RUN.
REQ-016 IDLE with START=0 SHALL stay IDLE; FIN with START=0 SHALL go IDLE.
REQ-017 RUN SHALL process one bit per cycle, LSB first: s = a^b^c, c' = a&b | c&(a^b), via two half-adder stages.
REQ-018 Each RUN cycle SHALL shift s into the result MSB, shift operands right, register c', increment counter.
REQ-019 RUN SHALL go to FIN after exactly WIDTH cycles (counter = WIDTH-1), including WIDTH=1.
REQ-020 START accepted at edge k SHALL give DONE=1 in the cycle after edge k+WIDTH; latency WIDTH+1 cycles.
REQ-021 BUSY SHALL be 1 exactly in RUN; DONE SHALL be 1 exactly in FIN.
REQ-022 START while in RUN SHALL be ignored; operands/result SHALL not be disturbed.
REQ-023 START in FIN SHALL be accepted (back-to-back), giving one DONE pulse per operation, no idle gap.
REQ-024 SUM, COUT, OVF SHALL update only at the RUN->FIN transition and hold until the next FIN.
REQ-025 COUT SHALL be the final carry; OVF SHALL be carry-into-MSB XOR COUT.
REQ-026 Input changes outside the accept cycle SHALL not affect the running operation.

Reset
REQ-027 RST_N=0 at a rising edge SHALL force IDLE, counter 0, BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0.
REQ-028 Reset SHALL override START and abort any RUN in progress; no DONE for the aborted operation.
REQ-029 First START after reset release SHALL be accepted normally.

Configuration
REQ-030 Macro SERIAL_ADDER_SUB_EN SHALL control subtract support.
REQ-031 Defined: captured SUB=1 SHALL use ~B_IN and initial carry CIN|1 (A-B); COUT=1 means no borrow.
REQ-032 Undefined: SUB SHALL be ignored and always add; port SHALL remain present.

Verification (WIDTH=8 unless stated)
REQ-033 A=0x00,B=0x00,CIN=0 START at edge 0 -> BUSY edges 1..8, DONE after edge 9, SUM=0x00, COUT=0, OVF=0.
REQ-034 A=0xFF,B=0x01,CIN=0 -> SUM=0x00, COUT=1, OVF=0; A=0x7F,B=0x01 -> SUM=0x80, COUT=0, OVF=1.
REQ-035 START=1 held through RUN, new operands applied mid-run -> only first result reported; second op starts in FIN; two DONE pulses 9 cycles apart.
REQ-036 RST_N=0 at RUN cycle 4 -> next cycle BUSY=0, DONE=0, SUM=0; no DONE until a new START.
REQ-037 With SERIAL_ADDER_SUB_EN: A=0x05,B=0x07,SUB=1 -> SUM=0xFE, COUT=0; without: same stimulus -> SUM=0x0C, COUT=0.
REQ-038 WIDTH=1: A=1,B=1,CIN=1 -> SUM=1, COUT=1, DONE after edge 2.
